// File: rtl/maxpool2x2_stream.sv
`default_nettype none
// ============================================================================
// maxpool2x2_stream : 2x2 stride-2 max-pool over a raster-order conv stream
// Revision          : 1.0
// ============================================================================
module maxpool2x2_stream #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last
);

  localparam int HALF_W = IMG_W / 2;
  localparam int COL_W  = (IMG_W  > 2) ? $clog2(IMG_W)  : 1;
  localparam int ROW_W  = (IMG_H  > 2) ? $clog2(IMG_H)  : 1;
  localparam int LB_AW  = (HALF_W > 2) ? $clog2(HALF_W) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  if (((IMG_W % 2) != 0) || ((IMG_H % 2) != 0)) begin : g_dim_check
    $fatal(1, "maxpool2x2_stream: IMG_W and IMG_H must both be even");
  end

  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;

  logic [DATA_WIDTH-1:0] linebuf_q [HALF_W];
  logic [LB_AW-1:0]      lb_idx;
  logic                  lb_we;
  logic [DATA_WIDTH-1:0] lb_rdata;
  logic [DATA_WIDTH-1:0] pair_max;
  logic [DATA_WIDTH-1:0] win_max;

  assign lb_idx   = LB_AW'(col_q >> 1);
  assign lb_rdata = linebuf_q[lb_idx];
  assign pair_max = (in_data > hold_q) ? in_data : hold_q;
  assign win_max  = (lb_rdata > pair_max) ? lb_rdata : pair_max;

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    lb_we       = 1'b0;
    if (in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      // Even column opens a horizontal pair; odd column closes it.
      if (!col_q[0]) begin
        hold_d = in_data;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        out_data_d  = win_max;
        out_valid_d = 1'b1;
        out_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Line buffer is never reset: each entry is rewritten on every even row.
  always_ff @(posedge clk) begin
    if (lb_we && !rst) begin
      linebuf_q[lb_idx] <= pair_max;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_maxpool2x2_stream.sv
`default_nettype none
// ============================================================================
// tb_maxpool2x2_stream : randomized bench for maxpool2x2_stream (4x4 and 28x28)
// Revision             : 1.0
// ============================================================================
module tb_maxpool2x2_stream;

  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_s [2];
  logic          vld_s [2];
  logic [DW-1:0] dat_s [2];
  logic [DW-1:0] o_d   [2];
  logic          o_v   [2];
  logic          o_l   [2];

  maxpool2x2_stream #(.IMG_W(4), .IMG_H(4), .DATA_WIDTH(DW)) u_dut_small (
    .clk(clk), .rst(rst_s[0]), .in_data(dat_s[0]), .in_valid(vld_s[0]),
    .out_data(o_d[0]), .out_valid(o_v[0]), .out_last(o_l[0])
  );

  maxpool2x2_stream u_dut_full (
    .clk(clk), .rst(rst_s[1]), .in_data(dat_s[1]), .in_valid(vld_s[1]),
    .out_data(o_d[1]), .out_valid(o_v[1]), .out_last(o_l[1])
  );

  int            n_cmp = 0;
  int            n_err = 0;
  int            pos    [2];
  int            pulses [2];
  int            lasts  [2];
  logic [DW-1:0] exp_d  [2];
  logic [DW-1:0] pix    [2][28][28];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] max4(input logic [DW-1:0] a, b, c, d);
    logic [DW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Reference: place each accepted beat in a 2-D frame; the bottom-right
  // pixel of each 2x2 window yields the max of its four pixels next cycle.
  task automatic step(input int k, input string tag, input logic r, input logic v,
                      input logic [DW-1:0] d);
    int   w, row, col;
    logic ev, el;
    w  = (k == 0) ? 4 : 28;
    ev = 1'b0;
    el = 1'b0;
    rst_s[k] = r;
    vld_s[k] = v;
    dat_s[k] = d;
    if (r) begin
      pos[k]   = 0;
      exp_d[k] = '0;
    end else if (v) begin
      row = pos[k] / w;
      col = pos[k] % w;
      pix[k][row][col] = d;
      if ((row % 2 == 1) && (col % 2 == 1)) begin
        ev       = 1'b1;
        exp_d[k] = max4(pix[k][row-1][col-1], pix[k][row-1][col], pix[k][row][col-1], d);
        el       = (pos[k] == w * w - 1);
      end
      pos[k] = (pos[k] + 1) % (w * w);
    end
    @(posedge clk);
    #1;
    check($sformatf("%s.valid", tag), DW'(o_v[k]), DW'(ev));
    check($sformatf("%s.data", tag), o_d[k], exp_d[k]);
    check($sformatf("%s.last", tag), DW'(o_l[k]), DW'(el));
    if (o_v[k]) pulses[k]++;
    if (o_l[k]) lasts[k]++;
  endtask

  task automatic clr_counts(input int k);
    pulses[k] = 0;
    lasts[k]  = 0;
  endtask

  initial begin
    rst_s[0] = 1'b1; rst_s[1] = 1'b1;
    vld_s[0] = 1'b0; vld_s[1] = 1'b0;
    dat_s[0] = '0;   dat_s[1] = '0;
    pos[0] = 0; pos[1] = 0;
    exp_d[0] = '0; exp_d[1] = '0;
    clr_counts(0); clr_counts(1);

    // Reset state; rst with in_valid high must drop the beat
    step(0, "rst", 1'b1, 1'b0, 32'd0);
    step(0, "rst_vld", 1'b1, 1'b1, 32'd77);
    step(0, "idle", 1'b0, 1'b0, 32'd0);

    // 1: 0..15 back-to-back
    clr_counts(0);
    for (int i = 0; i < 16; i++) step(0, "t1", 1'b0, 1'b1, DW'(i));
    step(0, "t1_tail", 1'b0, 1'b0, 32'd0);
    check("t1.pulses", DW'(pulses[0]), 32'd4);
    check("t1.lasts", DW'(lasts[0]), 32'd1);
    check("t1.final", o_d[0], 32'd15);

    // 2: same stream, gap after every beat
    clr_counts(0);
    for (int i = 0; i < 16; i++) begin
      step(0, "t2", 1'b0, 1'b1, DW'(i));
      step(0, "t2_gap", 1'b0, 1'b0, $urandom);
    end
    check("t2.pulses", DW'(pulses[0]), 32'd4);
    check("t2.lasts", DW'(lasts[0]), 32'd1);

    // 3: two frames back-to-back
    clr_counts(0);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++) step(0, "t3", 1'b0, 1'b1, DW'(i + 100 * f));
    step(0, "t3_tail", 1'b0, 1'b0, 32'd0);
    check("t3.pulses", DW'(pulses[0]), 32'd8);
    check("t3.lasts", DW'(lasts[0]), 32'd2);

    // 4: reset after beat 9, then a full frame
    clr_counts(0);
    for (int i = 0; i < 10; i++) step(0, "t4_abort", 1'b0, 1'b1, DW'(200 + i));
    step(0, "t4_rst", 1'b1, 1'b1, 32'd999);
    for (int i = 0; i < 16; i++) step(0, "t4", 1'b0, 1'b1, DW'(i));
    step(0, "t4_tail", 1'b0, 1'b0, 32'd0);
    check("t4.pulses", DW'(pulses[0]), 32'd6);
    check("t4.lasts", DW'(lasts[0]), 32'd1);
    check("t4.final", o_d[0], 32'd15);

    // 5: all-ones in each quadrant position, against 0 and against random
    clr_counts(0);
    for (int q = 0; q < 8; q++) begin
      for (int i = 0; i < 16; i++) begin
        int quad;
        logic [DW-1:0] d;
        quad = ((i / 4) % 2) * 2 + (i % 4) % 2;
        d = (quad == (q % 4)) ? 32'hFFFF_FFFF : ((q < 4) ? 32'd0 : $urandom);
        step(0, "t5", 1'b0, 1'b1, d);
        if ($urandom_range(0, 3) == 0) step(0, "t5_gap", 1'b0, 1'b0, $urandom);
      end
    end
    check("t5.pulses", DW'(pulses[0]), 32'd32);
    check("t5.final", o_d[0], 32'hFFFF_FFFF);

    // 6: default 28x28, random data and random gaps
    step(1, "t6_rst", 1'b1, 1'b0, 32'd0);
    clr_counts(1);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 784; i++) begin
        step(1, "t6", 1'b0, 1'b1, $urandom);
        if ($urandom_range(0, 3) == 0) step(1, "t6_gap", 1'b0, 1'b0, $urandom);
      end
      check("t6.pulses", DW'(pulses[1]), DW'(196 * (f + 1)));
      check("t6.lasts", DW'(lasts[1]), DW'(f + 1));
    end
    step(1, "t6_tail", 1'b0, 1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
